// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package clk_div_pkg;

  // Controller states: stopped, free running, finishing the high phase before stopping.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Default width of the half-period divisor and its counter.
  localparam int DIV_W_DEF = 32;

  // Half-period in input clock cycles for a wanted output frequency (truncating).
  function automatic int unsigned half_from_freq(input int unsigned in_f,
                                                 input int unsigned out_f);
    return in_f / (2 * out_f);
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Half-period counter and divided-clock generator.
// Counts clk cycles up to half-1, then toggles new_clk and restarts from zero.
// tick marks every 0->1 transition of new_clk. clear parks the output low with
// the counter at zero, which is the idle condition of the controller.
module clk_div_cnt #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] half,
  output logic             new_clk,
  output logic             tick,
  output logic             tgl_rise,
  output logic             tgl_fall
);

  logic [DIV_W-1:0] cnt;
  logic             tgl;

  // The toggle point is the last cycle of the current half period; half is never 0.
  assign tgl      = run && (cnt == (half - DIV_W'(1)));
  assign tgl_rise = tgl & ~new_clk;
  assign tgl_fall = tgl & new_clk;

  // Count cycles within the half period and flip the divided clock at its end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      new_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      new_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (tgl) begin
      cnt     <= '0;
      new_clk <= ~new_clk;
      tick    <= ~new_clk;
    end else if (run) begin
      cnt     <= cnt + DIV_W'(1);
      tick    <= 1'b0;
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider controller.
// Sequences start/stop and divisor changes so that new_clk never shows a glitch
// or a runt phase: stopping always ends with the output low, and a new divisor
// written while running is buffered and only takes effect on a falling edge of
// new_clk, so every period in flight completes with the divisor it started with.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned IN_FREQ      = 50000000,
  parameter int unsigned DEF_OUT_FREQ = 9600,
  parameter int          DIV_W        = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_err,
  output logic             new_clk,
  output logic             tick,
  output logic             active,
  output logic [DIV_W-1:0] cur_half
);

  localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(half_from_freq(IN_FREQ, DEF_OUT_FREQ));

  state_t           state;
  logic             pend_vld;
  logic [DIV_W-1:0] pend_half;
  logic             xfer;
  logic             run;
  logic             clear;
  logic             tgl_rise;
  logic             tgl_fall;

  assign xfer = cfg_valid & cfg_ready;
  assign run  = (state != IDLE);

  // Hold the counter at zero while idle, and drop straight to idle when the
  // divider is disabled during a low phase that is not about to rise: cutting a
  // low phase short cannot produce a glitch because the output is already low.
  assign clear = (state == IDLE) |
                 ((state == RUN) & ~en & ~new_clk & ~tgl_rise);

  clk_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (clear),
    .half     (cur_half),
    .new_clk  (new_clk),
    .tick     (tick),
    .tgl_rise (tgl_rise),
    .tgl_fall (tgl_fall)
  );

  // Start/stop sequencing; active mirrors the next state so it is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state  <= RUN;
            active <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            if (tgl_fall) begin
              state  <= IDLE;
              active <= 1'b0;
            end else if (new_clk | tgl_rise) begin
              state  <= STOP;
              active <= 1'b1;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end
        end
        STOP: begin
          if (tgl_fall) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  // Divisor handshake: a zero divisor is rejected with an error pulse, an idle
  // divider takes a new value at once, and a running one buffers it until the
  // next falling edge of new_clk so the period in progress is not distorted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_half  <= DEF_HALF;
      pend_half <= '0;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (xfer) begin
        if (cfg_half == '0) begin
          cfg_err <= 1'b1;
        end else if (state == IDLE) begin
          cur_half <= cfg_half;
        end else begin
          pend_half <= cfg_half;
          pend_vld  <= 1'b1;
          cfg_ready <= 1'b0;
        end
      end else if (pend_vld && (tgl_fall || (state == IDLE))) begin
        cur_half  <= pend_half;
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: table of divisor settings with their
// expected waveform timing, plus hand-written sequences for handshake, stop
// and reset corner cases. Expected values are queued and popped on measurement.
module tb_clk_div_ctrl;

  localparam int          DIV_W    = 32;
  localparam logic [31:0] DEF_HALF = 32'd2604;
  localparam int          BOUND    = 20000;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             en        = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_half  = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             new_clk;
  logic             tick;
  logic             active;
  logic [DIV_W-1:0] cur_half;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    logic [31:0] half;
    int          exp_first;
    int          exp_hi;
    int          exp_lo;
    int          exp_ticks;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  clk_div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_err   (cfg_err),
    .new_clk   (new_clk),
    .tick      (tick),
    .active    (active),
    .cur_half  (cur_half)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] actual);
    exp_t e;
    n_compared++;
    if (sb_q.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_empty actual=%0d", actual);
    end else begin
      e = sb_q.pop_front();
      if (actual !== e.value) begin
        n_mismatched++;
        $display("[TB] FAIL %s actual=%0d required=%0d", e.name, actual, e.value);
      end
    end
  endtask

  // Offer a divisor and hold it until the handshake completes.
  task automatic apply_stimulus(input logic [31:0] half);
    int waited;
    waited    = 0;
    cfg_valid = 1'b1;
    cfg_half  = half;
    while (!cfg_ready && waited < 200) begin
      step();
      waited++;
    end
    step();
    cfg_valid = 1'b0;
    push_exp("cfg_handshake_done", 1);
    check_output(32'(waited < 200));
  endtask

  task automatic wait_rise(output int steps);
    steps = 0;
    while (!new_clk && steps < BOUND) begin
      step();
      steps++;
    end
  endtask

  task automatic stop_divider();
    int waited;
    waited = 0;
    en     = 1'b0;
    step();
    while (active && waited < BOUND) begin
      step();
      waited++;
    end
    push_exp("stopped_active", 0);
    check_output(32'(active));
    push_exp("stopped_new_clk", 0);
    check_output(32'(new_clk));
  endtask

  // Program a divisor while idle, start, and time the first full period.
  task automatic run_vector(input vec_t v);
    int first, hi, lo, ticks;
    apply_stimulus(v.half);
    push_exp("cur_half_idle", v.half);
    check_output(cur_half);
    en = 1'b1;
    push_exp("first_rise", v.exp_first);
    push_exp("tick_at_rise", 1);
    push_exp("high_len", v.exp_hi);
    push_exp("low_len", v.exp_lo);
    push_exp("ticks_per_period", v.exp_ticks);
    push_exp("tick_at_next_rise", 1);
    wait_rise(first);
    check_output(first);
    check_output(32'(tick));
    hi = 0; lo = 0; ticks = 0;
    while (new_clk && hi < BOUND) begin
      ticks += int'(tick);
      hi++;
      step();
    end
    while (!new_clk && lo < BOUND) begin
      ticks += int'(tick);
      lo++;
      step();
    end
    check_output(hi);
    check_output(lo);
    check_output(ticks);
    check_output(32'(tick));
    stop_divider();
  endtask

  initial begin
    int first, hi, lo, rises;

    // half, first rise (one cycle to leave IDLE plus half), high, low, ticks/period
    vecs[0] = '{half: 32'd3, exp_first: 4, exp_hi: 3, exp_lo: 3, exp_ticks: 1};
    vecs[1] = '{half: 32'd1, exp_first: 2, exp_hi: 1, exp_lo: 1, exp_ticks: 1};
    vecs[2] = '{half: 32'd4, exp_first: 5, exp_hi: 4, exp_lo: 4, exp_ticks: 1};
    vecs[3] = '{half: 32'd7, exp_first: 8, exp_hi: 7, exp_lo: 7, exp_ticks: 1};

    // Reset state
    repeat (3) step();
    rst = 1'b1;
    step();
    push_exp("reset_cur_half", DEF_HALF);  check_output(cur_half);
    push_exp("reset_new_clk", 0);          check_output(32'(new_clk));
    push_exp("reset_cfg_ready", 1);        check_output(32'(cfg_ready));
    push_exp("reset_active", 0);           check_output(32'(active));
    push_exp("reset_tick", 0);             check_output(32'(tick));
    push_exp("reset_cfg_err", 0);          check_output(32'(cfg_err));

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Divisor change while running: current period keeps 4, next uses 2
    apply_stimulus(32'd4);
    en = 1'b1;
    wait_rise(first);
    push_exp("chg_first_rise", 5);  check_output(first);
    hi = 1;
    cfg_valid = 1'b1;
    cfg_half  = 32'd2;
    step();
    cfg_valid = 1'b0;
    push_exp("chg_ready_low", 0);       check_output(32'(cfg_ready));
    push_exp("chg_half_kept", 4);       check_output(cur_half);
    while (new_clk && hi < BOUND) begin
      hi++;
      step();
    end
    push_exp("chg_old_high", 4);        check_output(hi);
    push_exp("chg_ready_back", 1);      check_output(32'(cfg_ready));
    push_exp("chg_half_new", 2);        check_output(cur_half);
    lo = 0;
    while (!new_clk && lo < BOUND) begin
      lo++;
      step();
    end
    push_exp("chg_new_low", 2);         check_output(lo);
    push_exp("chg_tick", 1);            check_output(32'(tick));
    hi = 0;
    while (new_clk && hi < BOUND) begin
      hi++;
      step();
    end
    push_exp("chg_new_high", 2);        check_output(hi);

    // Zero divisor while running
    apply_stimulus(32'd0);
    push_exp("run_zero_err", 1);        check_output(32'(cfg_err));
    push_exp("run_zero_ready", 1);      check_output(32'(cfg_ready));
    push_exp("run_zero_half", 2);       check_output(cur_half);
    step();
    push_exp("run_zero_err_once", 0);   check_output(32'(cfg_err));
    stop_divider();

    // Zero divisor while idle
    apply_stimulus(32'd0);
    push_exp("idle_zero_err", 1);       check_output(32'(cfg_err));
    push_exp("idle_zero_half", 2);      check_output(cur_half);
    step();
    push_exp("idle_zero_err_once", 0);  check_output(32'(cfg_err));

    // Disable on the cycle of a rising toggle: rise with tick, finish high, stop
    apply_stimulus(32'd3);
    en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    step();
    push_exp("late_stop_rise", 1);      check_output(32'(new_clk));
    push_exp("late_stop_tick", 1);      check_output(32'(tick));
    push_exp("late_stop_active", 1);    check_output(32'(active));
    hi = 0;
    while (new_clk && hi < BOUND) begin
      hi++;
      step();
    end
    push_exp("late_stop_high", 3);      check_output(hi);
    push_exp("late_stop_idle", 0);      check_output(32'(active));

    // Disable mid-high with half=5: high phase completes, then idle
    apply_stimulus(32'd5);
    en = 1'b1;
    wait_rise(first);
    hi = 0;
    while (new_clk && hi < BOUND) begin
      if (hi == 2) en = 1'b0;
      hi++;
      step();
    end
    push_exp("stop_high_len", 5);       check_output(hi);
    push_exp("stop_high_active", 0);    check_output(32'(active));
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      rises += int'(new_clk) + int'(tick);
      step();
    end
    push_exp("stop_stays_low", 0);      check_output(rises);

    // Disable mid-low: idle on the next cycle, output low
    en = 1'b1;
    repeat (3) step();
    push_exp("low_stop_was_active", 1); check_output(32'(active));
    en = 1'b0;
    step();
    push_exp("low_stop_active", 0);     check_output(32'(active));
    push_exp("low_stop_new_clk", 0);    check_output(32'(new_clk));

    // Reset mid-high with a pending divisor
    en = 1'b1;
    wait_rise(first);
    apply_stimulus(32'd7);
    push_exp("rst_pending", 0);         check_output(32'(cfg_ready));
    push_exp("rst_pre_high", 1);        check_output(32'(new_clk));
    #2;
    rst = 1'b0;
    #1;
    push_exp("rst_async_clk", 0);       check_output(32'(new_clk));
    push_exp("rst_async_active", 0);    check_output(32'(active));
    en = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    push_exp("rst_cur_half", DEF_HALF); check_output(cur_half);
    push_exp("rst_ready", 1);           check_output(32'(cfg_ready));
    push_exp("rst_new_clk", 0);         check_output(32'(new_clk));

    if (sb_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
